// File: rtl/fifo_cdc_pkg.sv
// Shared helpers for the dual-clock FIFO pointer blocks: Gray/binary conversion
// and the smallest legal parameter values.
package fifo_cdc_pkg;

  localparam int MIN_FIFO_DEPTH  = 2;
  localparam int MIN_SYNC_STAGES = 2;
  localparam int PTR_MAX_W       = 32;

  // Callers zero-extend their pointer to PTR_MAX_W and cast the result back down.
  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wptr_full_lvl_if.sv
// Write-side bundle between the producer, the write-pointer block and the read domain.
interface fifo_wptr_full_lvl_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int A = $clog2(FIFO_DEPTH);
  localparam int P = A + 1;

  // Handshake: wr_en is the request, wr_ack = wr_en & ~full is the accept, and
  // the RAM writes wr_addr on every wr_clk edge where wr_ack is high; a request
  // without accept is dropped (not held) and flagged on overflow.
  logic         wr_en;
  logic [P-1:0] af_thresh;
  logic         ovf_clr;
  logic [P-1:0] rptr_gray_async;
  logic         wr_ack;
  logic [A-1:0] wr_addr;
  logic [P-1:0] wptr_bin;
  logic [P-1:0] wptr_gray;
  logic         full;
  logic         almost_full;
  logic [P-1:0] wr_level;
  logic         overflow;

  modport master (
    output wr_en, af_thresh, ovf_clr, rptr_gray_async,
    input  wr_ack, wr_addr, wptr_bin, wptr_gray, full, almost_full, wr_level, overflow
  );

  modport slave (
    input  wr_en, af_thresh, ovf_clr, rptr_gray_async,
    output wr_ack, wr_addr, wptr_bin, wptr_gray, full, almost_full, wr_level, overflow
  );

endinterface

// File: rtl/fifo_ptr_sync.sv
// Plain flop-chain synchronizer for a Gray pointer crossing into this clock domain.
module fifo_ptr_sync #(
  parameter int WIDTH  = 3,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/fifo_wptr_full_lvl.sv
// Write-domain pointer, full/almost-full, level and sticky overflow for the CDC FIFO.
module fifo_wptr_full_lvl
  import fifo_cdc_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst_n,
  fifo_wptr_full_lvl_if.slave   bus
);

  localparam int A = $clog2(FIFO_DEPTH);
  localparam int P = A + 1;

  if (FIFO_DEPTH < MIN_FIFO_DEPTH || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "fifo_wptr_full_lvl: FIFO_DEPTH must be a power of two >= 2");
  end
  if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
    $fatal(1, "fifo_wptr_full_lvl: SYNC_STAGES must be >= 2");
  end

  logic [P-1:0] rgray_sync;
  logic [P-1:0] rbin_sync;
  logic [P-1:0] wbin_next;
  logic [P-1:0] wgray_next;
  logic [P-1:0] lvl_next;
  logic         ack;

  logic [P-1:0] wptr_bin_q;
  logic [P-1:0] wptr_gray_q;
  logic [P-1:0] level_q;
  logic         full_q;
  logic         af_q;
  logic         ovf_q;

  fifo_ptr_sync #(
    .WIDTH  (P),
    .STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .clk   (wr_clk),
    .rst_n (wr_rst_n),
    .d     (bus.rptr_gray_async),
    .q     (rgray_sync)
  );

  // Level uses the lagging read pointer, so it can only over-report occupancy.
  always_comb begin
    ack        = bus.wr_en & ~full_q;
    rbin_sync  = P'(gray2bin(PTR_MAX_W'(rgray_sync)));
    wbin_next  = wptr_bin_q + P'(ack);
    wgray_next = P'(bin2gray(PTR_MAX_W'(wbin_next)));
    lvl_next   = wbin_next - rbin_sync;
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      wptr_bin_q  <= '0;
      wptr_gray_q <= '0;
      level_q     <= '0;
      full_q      <= 1'b0;
      af_q        <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      wptr_bin_q  <= wbin_next;
      wptr_gray_q <= wgray_next;
      level_q     <= lvl_next;
      full_q      <= (lvl_next == P'(FIFO_DEPTH));
      af_q        <= (lvl_next >= bus.af_thresh);
      // A new overflow event outranks a clear in the same cycle.
      ovf_q       <= (bus.wr_en & full_q) | (ovf_q & ~bus.ovf_clr);
    end
  end

  assign bus.wr_ack      = ack;
  assign bus.wr_addr     = wptr_bin_q[A-1:0];
  assign bus.wptr_bin    = wptr_bin_q;
  assign bus.wptr_gray   = wptr_gray_q;
  assign bus.wr_level    = level_q;
  assign bus.full        = full_q;
  assign bus.almost_full = af_q;
  assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_fifo_wptr_full_lvl.sv
// Bench for fifo_wptr_full_lvl: directed vector table, reset/depth-2 sequences and a
// randomized run against a count-based occupancy model.
module tb_fifo_wptr_full_lvl;

  localparam int S = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  fifo_wptr_full_lvl_if #(.FIFO_DEPTH(4)) ia ();
  fifo_wptr_full_lvl_if #(.FIFO_DEPTH(2)) ib ();

  fifo_wptr_full_lvl #(.FIFO_DEPTH(4), .SYNC_STAGES(S)) dut_a (
    .wr_clk   (clk),
    .wr_rst_n (rst_n),
    .bus      (ia)
  );

  fifo_wptr_full_lvl #(.FIFO_DEPTH(2), .SYNC_STAGES(S)) dut_b (
    .wr_clk   (clk),
    .wr_rst_n (rst_n),
    .bus      (ib)
  );

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic en;
    logic clr;
    int   rgray;
    int   e_ack;
    int   e_lvl;
    int   e_full;
    int   e_af;
    int   e_ovf;
    int   e_bin;
    int   e_gray;
    int   e_addr;
  } vec_t;

  vec_t vecs [11];
  logic [2:0] exp_q [$];
  int hist [$];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int gray(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ia.wr_en = 1'b0; ia.ovf_clr = 1'b0; ia.af_thresh = '0; ia.rptr_gray_async = '0;
    ib.wr_en = 1'b0; ib.ovf_clr = 1'b0; ib.af_thresh = '0; ib.rptr_gray_async = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic chk_zero_a(input string tag);
    chk({tag, "_bin"},  int'(ia.wptr_bin), 0);
    chk({tag, "_gray"}, int'(ia.wptr_gray), 0);
    chk({tag, "_addr"}, int'(ia.wr_addr), 0);
    chk({tag, "_lvl"},  int'(ia.wr_level), 0);
    chk({tag, "_full"}, int'(ia.full), 0);
    chk({tag, "_af"},   int'(ia.almost_full), 0);
    chk({tag, "_ovf"},  int'(ia.overflow), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int wcnt, rcnt, rs, lvl, thr;
    logic en, clr, m_full, m_ovf, m_af, exp_ack, saw_wrap;
    int prev_bin;

    // en clr rgray | ack lvl full af ovf bin gray addr
    vecs[0]  = '{1'b1, 1'b0, 0, 1, 1, 0, 0, 0, 1, 1, 1};
    vecs[1]  = '{1'b1, 1'b0, 0, 1, 2, 0, 0, 0, 2, 3, 2};
    vecs[2]  = '{1'b1, 1'b0, 0, 1, 3, 0, 1, 0, 3, 2, 3};
    vecs[3]  = '{1'b1, 1'b0, 0, 1, 4, 1, 1, 0, 4, 6, 0};
    vecs[4]  = '{1'b1, 1'b0, 0, 0, 4, 1, 1, 1, 4, 6, 0};
    vecs[5]  = '{1'b1, 1'b1, 0, 0, 4, 1, 1, 1, 4, 6, 0};
    vecs[6]  = '{1'b0, 1'b1, 0, 0, 4, 1, 1, 0, 4, 6, 0};
    vecs[7]  = '{1'b0, 1'b0, 1, 0, 4, 1, 1, 0, 4, 6, 0};
    vecs[8]  = '{1'b0, 1'b0, 1, 0, 4, 1, 1, 0, 4, 6, 0};
    vecs[9]  = '{1'b0, 1'b0, 1, 0, 3, 0, 1, 0, 4, 6, 0};
    vecs[10] = '{1'b1, 1'b0, 1, 1, 4, 1, 1, 0, 5, 7, 1};

    idle_inputs();
    #2;
    chk_zero_a("rst");
    chk("rst_b_lvl", int'(ib.wr_level), 0);
    chk("rst_b_af", int'(ib.almost_full), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed table on the depth-4 instance.
    ia.af_thresh = 3'd3;
    for (int i = 0; i < 11; i++) begin
      ia.wr_en = vecs[i].en;
      ia.ovf_clr = vecs[i].clr;
      ia.rptr_gray_async = 3'(vecs[i].rgray);
      #1;
      chk($sformatf("v%0d_ack", i), int'(ia.wr_ack), vecs[i].e_ack);
      tick();
      chk($sformatf("v%0d_lvl", i),  int'(ia.wr_level), vecs[i].e_lvl);
      chk($sformatf("v%0d_full", i), int'(ia.full), vecs[i].e_full);
      chk($sformatf("v%0d_af", i),   int'(ia.almost_full), vecs[i].e_af);
      chk($sformatf("v%0d_ovf", i),  int'(ia.overflow), vecs[i].e_ovf);
      chk($sformatf("v%0d_bin", i),  int'(ia.wptr_bin), vecs[i].e_bin);
      chk($sformatf("v%0d_gray", i), int'(ia.wptr_gray), vecs[i].e_gray);
      chk($sformatf("v%0d_addr", i), int'(ia.wr_addr), vecs[i].e_addr);
    end

    // Asynchronous reset while full, no clock edge in between.
    #2;
    rst_n = 1'b0;
    ia.rptr_gray_async = '0;
    ia.ovf_clr = 1'b0;
    ia.wr_en = 1'b1;
    #1;
    chk_zero_a("mid_rst");
    chk("mid_rst_ack", int'(ia.wr_ack), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_addr", int'(ia.wr_addr), 0);
    chk("post_rst_ack", int'(ia.wr_ack), 1);
    tick();
    chk("post_rst_gray", int'(ia.wptr_gray), 1);
    chk("post_rst_bin", int'(ia.wptr_bin), 1);

    // Randomized writes/reads against an occupancy model built from counts.
    do_reset();
    wcnt = 0; rcnt = 0; m_full = 1'b0; m_ovf = 1'b0;
    hist.delete();
    exp_q.delete();
    saw_wrap = 1'b0;
    prev_bin = 0;
    for (int cyc = 0; cyc < 300 && wcnt < 24; cyc++) begin
      en  = ($urandom_range(0, 9) < 7);
      clr = ($urandom_range(0, 7) == 0);
      thr = $urandom_range(0, 4);
      if (rcnt < wcnt && $urandom_range(0, 1) == 1) rcnt++;
      ia.wr_en = en;
      ia.ovf_clr = clr;
      ia.af_thresh = 3'(thr);
      ia.rptr_gray_async = 3'(gray(rcnt % 8));
      #1;
      exp_ack = en && !m_full;
      chk("rnd_ack", int'(ia.wr_ack), int'(exp_ack));
      chk("rnd_addr", int'(ia.wr_addr), wcnt % 4);

      hist.push_back(rcnt);
      rs = (hist.size() > S) ? hist[hist.size() - 1 - S] : 0;
      m_ovf = (en && m_full) ? 1'b1 : (clr ? 1'b0 : m_ovf);
      wcnt += int'(exp_ack);
      lvl = wcnt - rs;
      m_full = (lvl == 4);
      m_af = (lvl >= thr);
      exp_q.push_back(3'(lvl));

      tick();
      chk("rnd_lvl", int'(ia.wr_level), int'(exp_q.pop_front()));
      chk("rnd_full", int'(ia.full), int'(m_full));
      chk("rnd_af", int'(ia.almost_full), int'(m_af));
      chk("rnd_ovf", int'(ia.overflow), int'(m_ovf));
      chk("rnd_bin", int'(ia.wptr_bin), wcnt % 8);
      chk("rnd_gray", int'(ia.wptr_gray), gray(wcnt % 8));
      if (prev_bin == 7 && int'(ia.wptr_bin) == 0) saw_wrap = 1'b1;
      prev_bin = int'(ia.wptr_bin);
    end
    chk("rnd_bin_wrap", int'(saw_wrap), 1);

    // Depth-2 instance with a zero almost-full threshold.
    do_reset();
    ib.af_thresh = '0;
    ib.wr_en = 1'b0;
    tick();
    chk("d2_af_first", int'(ib.almost_full), 1);
    chk("d2_lvl0", int'(ib.wr_level), 0);
    ib.wr_en = 1'b1;
    #1;
    chk("d2_ack1", int'(ib.wr_ack), 1);
    tick();
    chk("d2_lvl1", int'(ib.wr_level), 1);
    chk("d2_full1", int'(ib.full), 0);
    #1;
    chk("d2_ack2", int'(ib.wr_ack), 1);
    tick();
    chk("d2_lvl2", int'(ib.wr_level), 2);
    chk("d2_full2", int'(ib.full), 1);
    chk("d2_af2", int'(ib.almost_full), 1);
    #1;
    chk("d2_ack3", int'(ib.wr_ack), 0);
    tick();
    chk("d2_ovf", int'(ib.overflow), 1);
    chk("d2_bin", int'(ib.wptr_bin), 2);
    chk("d2_gray", int'(ib.wptr_gray), 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fifo_wptr_full_lvl.md
# fifo_wptr_full_lvl

Write-domain pointer, flag and level block for the dual-clock FIFO used in the AXI4-Lite to APB bridge CDC path. It is the parametrised successor of the basic write-pointer/FULL block and adds four things: an internal read-pointer synchronizer, an occupancy level output, a programmable almost-full flag, and a sticky overflow error. It sits between the write-side producer (AXI slave front end) and the FIFO RAM. It sends a Gray write pointer to the read domain and receives the raw Gray read pointer from it.

## Interface
Parameters:
- FIFO_DEPTH, 4: number of entries. Must be a power of two and at least 2. Any other value causes `$fatal` at elaboration.
- SYNC_STAGES, 2: number of flops in the read-pointer synchronizer. Must be at least 2, otherwise `$fatal`.
- Derived: A = $clog2(FIFO_DEPTH) and P = A+1.

Ports (reset wr_rst_n, asynchronous, active-low; clock wr_clk):
- wr_clk  in  1  write-domain clock
- wr_rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write request
- af_thresh  in  P  almost-full threshold, legal range 0..FIFO_DEPTH
- ovf_clr  in  1  clears the sticky overflow flag
- rptr_gray_async  in  P  read pointer in Gray code, driven from the read domain and unsynchronized
- wr_ack  out  1  combinational; equals wr_en & ~full, so the RAM write happens this cycle
- wr_addr  out  A  RAM write address, equal to wptr_bin[A-1:0]
- wptr_bin  out  P  binary write pointer, including the wrap bit
- wptr_gray  out  P  Gray write pointer, sent to the read domain
- full  out  1  FIFO full
- almost_full  out  1  high when level >= af_thresh
- wr_level  out  P  occupancy as seen from the write domain, range 0..FIFO_DEPTH
- overflow  out  1  sticky flag: a write was attempted while full

## Operation
- Synchronizer: a chain of SYNC_STAGES flops carries rptr_gray_async into rgray_sync. It has no logic between stages and resets to 0.
- rbin_sync = gray2bin(rgray_sync). This path is combinational.
- wbin_next = wptr_bin + wr_ack, taken mod 2^P. wgray_next = wbin_next ^ (wbin_next >> 1).
- lvl_next = (wbin_next - rbin_sync), taken mod 2^P, in unsigned P-bit arithmetic.
- Registered updates on every wr_clk edge:
  - wptr_bin <= wbin_next
  - wptr_gray <= wgray_next
  - wr_level <= lvl_next
  - full <= (lvl_next == FIFO_DEPTH)
  - almost_full <= (lvl_next >= af_thresh)
- The full rule above is equivalent to the Gray rule "wgray_next equals rgray_sync with its top two bits inverted". Unlike that rule, it stays valid for FIFO_DEPTH = 2.
- Write while full: the write is dropped. The pointer, address and level do not change, and overflow is set on the next edge.
- overflow clears on an edge where ovf_clr = 1. If ovf_clr is asserted in the same cycle as a new overflow event, set wins.
- af_thresh = 0: almost_full is high on every edge after reset. af_thresh above FIFO_DEPTH is illegal, and almost_full then stays 0.
- Wrap-around: the binary pointer rolls over from 2^P-1 to 0. The level arithmetic handles this naturally, and wr_addr wraps every FIFO_DEPTH writes.
- The flags are pessimistic. Because of synchronizer lag, full and wr_level may over-report occupancy. They never under-report it.

## Timing
- Reset is asynchronous. All flops go to 0, including the synchronizer chain and every registered output. wr_ack follows wr_en, because full is 0 during reset. Reset asserted in mid-operation discards pointer state immediately, and the read domain is expected to be reset together with it.
- Write latency:
  - The RAM samples wr_addr at the edge where wr_ack = 1.
  - wptr_bin, wptr_gray, wr_level, full and almost_full reflect that write right after the same edge, so latency is 0 cycles for the flags.
  - The write that fills the last entry asserts full at that same edge.
- Read-pointer latency: a change on rptr_gray_async appears on rgray_sync after SYNC_STAGES edges. It then affects full, wr_level and almost_full on the next edge, SYNC_STAGES+1 edges after the change.
- Simultaneous write and synchronized read advance: both are folded into lvl_next in the same cycle, so the level is unchanged.
- wptr_gray is a direct register output with no combinational path, which keeps it safe to synchronize in the read domain.

## Structure
- Package fifo_cdc_pkg holds:
  - function gray2bin (parametrised by width through a P-bit wrapper, or a loop)
  - function bin2gray
  - the minimum-legal-parameter constants
- Sub-module fifo_ptr_sync, with parameters WIDTH and STAGES, is the plain flop-chain synchronizer with async active-low reset. The read-side successor reuses it.
- The top module holds the pointer, level, flag and overflow registers. The expected size is about 150–250 lines.

## Test plan
- DEPTH=4, rptr held at 0, af_thresh=3. Apply 4 consecutive writes. Required:
  - wr_level steps 1, 2, 3, 4
  - almost_full goes high after the 3rd edge
  - full goes high after the 4th edge
  - wptr_gray = 3'b110, wr_addr = 0
- Continue from the full state with a 5th write. Required:
  - wr_ack = 0
  - the pointer stays at 4
  - overflow = 1 after the edge
  - asserting ovf_clr and wr_en together leaves overflow = 1; ovf_clr alone clears it
- From full, set rptr_gray_async = gray(1) = 3'b001. Required: full falls and wr_level = 3 exactly SYNC_STAGES+1 edges later, not earlier.
- Wrap-around test:
  - Stimulus: 20 writes interleaved with read-pointer increments, each read pointer a proper Gray value, DEPTH=4.
  - Required: wr_addr cycles 0–3, wptr_bin wraps 7 to 0, and wr_level always equals the model count delayed by the sync lag.
- Assert wr_rst_n low in mid-burst while full. Required: every output reads 0 immediately, without waiting for a clock, and the first write after release produces wr_addr = 0 and wptr_gray = 3'b001.
- DEPTH=2 with af_thresh=0. Required: almost_full = 1 after the first edge, and full after 2 writes when rptr = 0.
